// File: rtl/ms_arb_pkg.sv
// Shared types and constants for the multi-stream input arbiter.
package ms_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } flow_state_t;

  localparam int ARB_SIZE_W = 7;
  localparam int STAT_W     = 16;

  // Block length: ext_size squared needs twice the ext_size width.
  typedef logic [2*ARB_SIZE_W-1:0] blk_len_t;

  function automatic int tag_w(input int flux);
    return (flux > 2) ? $clog2(flux) : 1;
  endfunction

endpackage

// File: rtl/ms_rr_grant.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
// Returns the one-hot grant, its index and whether anything was granted.
module ms_rr_grant #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/ms_input_arbiter.sv
// Round-robin merge of FLUX armed pixel flows into one tagged write port; output registered, 1 cycle after grant.
// Ready is the grant; a flow waits on its own out_full and on its own word in flight. Stats counters: MS_ARB_STATS_EN.
module ms_input_arbiter
  import ms_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FLUX   = 2,
  parameter int TAG_W  = tag_w(FLUX),
  parameter int SIZE_W = ARB_SIZE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_W+SIZE_W-1:0]  cfg_din,
  input  logic                     cfg_write,
  input  logic [FLUX*DATA_W-1:0]   src_data,
  input  logic [FLUX-1:0]          src_valid,
  output logic [FLUX-1:0]          src_ready,
  output logic [TAG_W+DATA_W-1:0]  out_din,
  output logic                     out_write,
  input  logic [FLUX-1:0]          out_full,
  output logic [FLUX-1:0]          flow_busy,
  output logic [FLUX-1:0]          flow_done,
  output logic                     cfg_err
`ifdef MS_ARB_STATS_EN
  ,
  output logic [FLUX*STAT_W-1:0]   stat_grant,
  output logic [FLUX*STAT_W-1:0]   stat_stall
`endif
);

  localparam int BLK_W = 2*SIZE_W;

  flow_state_t      state   [FLUX];
  flow_state_t      state_d [FLUX];
  logic [BLK_W-1:0] remaining [FLUX];

  logic [TAG_W-1:0]  rr_ptr;
  logic [FLUX-1:0]   req;
  logic [FLUX-1:0]   gnt;
  logic [TAG_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [FLUX-1:0]   last;
  logic [FLUX-1:0]   arm;
  logic [FLUX-1:0]   tag_hit;

  logic [TAG_W-1:0]  cfg_tag;
  logic [SIZE_W-1:0] cfg_size;
  logic [BLK_W-1:0]  cfg_len;
  logic              cfg_accept;
  logic [TAG_W-1:0]  out_tag;

  assign cfg_tag  = cfg_din[TAG_W+SIZE_W-1:SIZE_W];
  assign cfg_size = cfg_din[SIZE_W-1:0];
  assign cfg_len  = BLK_W'(cfg_size) * BLK_W'(cfg_size);
  assign out_tag  = out_din[TAG_W+DATA_W-1:DATA_W];

  // A tag outside 0..FLUX-1 hits no flow and is therefore rejected.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      tag_hit[i]   = (int'(cfg_tag) == i);
      flow_busy[i] = (state[i] == ACTIVE);
    end
    cfg_accept = cfg_write && (cfg_size != '0) && |(tag_hit & ~flow_busy);
    arm        = cfg_accept ? tag_hit : '0;
  end

  // Excluding the flow whose word sits in the output register keeps exact-full safe.
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      req[i] = flow_busy[i] && src_valid[i] && !out_full[i]
               && !(out_write && (int'(out_tag) == i));
    end
  end

  ms_rr_grant #(
    .N     (FLUX),
    .IDX_W (TAG_W)
  ) u_rr_grant (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign src_ready = gnt;

  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      state_d[i] = state[i];
      last[i]    = 1'b0;
      case (state[i])
        IDLE: begin
          if (arm[i]) state_d[i] = ACTIVE;
        end
        ACTIVE: begin
          if (gnt[i] && (remaining[i] == BLK_W'(1))) begin
            state_d[i] = IDLE;
            last[i]    = 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < FLUX; i++) state[i] <= state_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) remaining[i] <= '0;
      rr_ptr    <= '0;
      out_din   <= '0;
      out_write <= 1'b0;
      flow_done <= '0;
      cfg_err   <= 1'b0;
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (arm[i])
          remaining[i] <= cfg_len;
        else if (gnt[i])
          remaining[i] <= remaining[i] - BLK_W'(1);
      end
      flow_done <= last;
      cfg_err   <= cfg_write && !cfg_accept;
      out_write <= gnt_any;
      if (gnt_any) begin
        out_din <= {gnt_idx, src_data[int'(gnt_idx)*DATA_W +: DATA_W]};
        rr_ptr  <= (int'(gnt_idx) == FLUX-1) ? '0 : gnt_idx + TAG_W'(1);
      end
    end
  end

`ifdef MS_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [FLUX];
  logic [STAT_W-1:0] stall_cnt [FLUX];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLUX; i++) begin
        grant_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (arm[i]) begin
          grant_cnt[i] <= '0;
          stall_cnt[i] <= '0;
        end else begin
          if (gnt[i] && (grant_cnt[i] != '1))
            grant_cnt[i] <= grant_cnt[i] + STAT_W'(1);
          if (flow_busy[i] && src_valid[i] && !gnt[i] && (stall_cnt[i] != '1))
            stall_cnt[i] <= stall_cnt[i] + STAT_W'(1);
        end
      end
    end
  end

  for (genvar gi = 0; gi < FLUX; gi++) begin : g_stat
    assign stat_grant[gi*STAT_W +: STAT_W] = grant_cnt[gi];
    assign stat_stall[gi*STAT_W +: STAT_W] = stall_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_ms_input_arbiter.sv
// Randomised bench for ms_input_arbiter against a per-cycle behavioural model and per-flow data sequences.
module tb_ms_input_arbiter;
  import ms_arb_pkg::*;

  localparam int DATA_W = 8;
  localparam int FLUX   = 2;
  localparam int SIZE_W = 7;
  localparam int TAG_W  = tag_w(FLUX);
  localparam int FLUX3  = 3;
  localparam int TAG3_W = tag_w(FLUX3);

  logic                    clk = 1'b0;
  logic                    rst;
  logic [TAG_W+SIZE_W-1:0] cfg_din;
  logic                    cfg_write;
  logic [FLUX*DATA_W-1:0]  src_data;
  logic [FLUX-1:0]         src_valid;
  logic [FLUX-1:0]         src_ready;
  logic [TAG_W+DATA_W-1:0] out_din;
  logic                    out_write;
  logic [FLUX-1:0]         out_full;
  logic [FLUX-1:0]         flow_busy;
  logic [FLUX-1:0]         flow_done;
  logic                    cfg_err;

  logic [TAG3_W+SIZE_W-1:0] cfg_din3;
  logic                     cfg_write3;
  logic [FLUX3*DATA_W-1:0]  src_data3;
  logic [FLUX3-1:0]         src_valid3;
  logic [FLUX3-1:0]         src_ready3;
  logic [TAG3_W+DATA_W-1:0] out_din3;
  logic                     out_write3;
  logic [FLUX3-1:0]         out_full3;
  logic [FLUX3-1:0]         flow_busy3;
  logic [FLUX3-1:0]         flow_done3;
  logic                     cfg_err3;

`ifdef MS_ARB_STATS_EN
  logic [FLUX*STAT_W-1:0]  stat_grant, stat_stall;
  logic [FLUX3*STAT_W-1:0] stat_grant3, stat_stall3;
`endif

  always #5 clk = ~clk;

  ms_input_arbiter #(.DATA_W(DATA_W), .FLUX(FLUX), .SIZE_W(SIZE_W)) dut (
    .clk(clk), .rst(rst), .cfg_din(cfg_din), .cfg_write(cfg_write),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .out_din(out_din), .out_write(out_write), .out_full(out_full),
    .flow_busy(flow_busy), .flow_done(flow_done), .cfg_err(cfg_err)
`ifdef MS_ARB_STATS_EN
    , .stat_grant(stat_grant), .stat_stall(stat_stall)
`endif
  );

  ms_input_arbiter #(.DATA_W(DATA_W), .FLUX(FLUX3), .SIZE_W(SIZE_W)) dut3 (
    .clk(clk), .rst(rst), .cfg_din(cfg_din3), .cfg_write(cfg_write3),
    .src_data(src_data3), .src_valid(src_valid3), .src_ready(src_ready3),
    .out_din(out_din3), .out_write(out_write3), .out_full(out_full3),
    .flow_busy(flow_busy3), .flow_done(flow_done3), .cfg_err(cfg_err3)
`ifdef MS_ARB_STATS_EN
    , .stat_grant(stat_grant3), .stat_stall(stat_stall3)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  bit              m_active [FLUX];
  int              m_rem    [FLUX];
  int              m_rr;
  bit              e_ow;
  int              e_tag;
  logic [TAG_W+DATA_W-1:0] e_odin;
  logic [FLUX-1:0] e_done;
  bit              e_err;
  int              seq      [FLUX];
  int              m_grants [FLUX];
  int              m_dones  [FLUX];
  int              m_sg     [FLUX];
  int              m_stall  [FLUX];

  int              obs_words [FLUX];
  int              obs_done  [FLUX];
  int              cyc = 0;
  int              cyc_bad = 0;
  string           bad_msg = "";
  int              first_any, last_any;

  function automatic logic [DATA_W-1:0] pix(input int f, input int n);
    return DATA_W'((f*101 + n*37 + 11) & 255);
  endfunction

  function automatic void log_bad(input string s);
    cyc_bad++;
    if (bad_msg == "") bad_msg = $sformatf("cyc%0d %s", cyc, s);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < FLUX; i++) begin
      m_active[i] = 1'b0;
      m_rem[i]    = 0;
    end
    m_rr = 0; e_ow = 1'b0; e_tag = 0; e_odin = '0; e_done = '0; e_err = 1'b0;
  endfunction

  task automatic arm(input int t, input int s);
    cfg_din   = {TAG_W'(t), SIZE_W'(s)};
    cfg_write = 1'b1;
  endtask

  // One clock: predict from the rules, let the DUT clock, compare at the falling edge.
  task automatic tick();
    int g, pos, ctag, csize;
    bit ok;
    logic [FLUX-1:0] exp_rdy, exp_busy;
    for (int i = 0; i < FLUX; i++) src_data[i*DATA_W +: DATA_W] = pix(i, seq[i]);
    g = -1;
    for (int k = 0; k < FLUX; k++) begin
      pos = (m_rr + k) % FLUX;
      if (g < 0 && m_active[pos] && src_valid[pos] && !out_full[pos] && !(e_ow && e_tag == pos))
        g = pos;
    end
    ctag  = int'(cfg_din[SIZE_W +: TAG_W]);
    csize = int'(cfg_din[SIZE_W-1:0]);
    ok    = cfg_write && ctag < FLUX && !m_active[ctag] && csize != 0;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    if (src_ready !== exp_rdy) log_bad($sformatf("src_ready got %b want %b", src_ready, exp_rdy));
    @(posedge clk);
    for (int i = 0; i < FLUX; i++)
      if (m_active[i] && src_valid[i] && g != i) m_stall[i]++;
    e_done = '0;
    e_ow   = (g >= 0);
    if (g >= 0) begin
      e_tag  = g;
      e_odin = {TAG_W'(g), pix(g, seq[g])};
      seq[g]++; m_grants[g]++; m_sg[g]++; m_rem[g]--;
      m_rr = (g + 1) % FLUX;
      if (m_rem[g] == 0) begin
        m_active[g] = 1'b0;
        e_done[g]   = 1'b1;
        m_dones[g]++;
      end
    end
    e_err = cfg_write && !ok;
    if (ok) begin
      m_active[ctag] = 1'b1;
      m_rem[ctag]    = csize * csize;
      m_sg[ctag]     = 0;
      m_stall[ctag]  = 0;
    end
    @(negedge clk);
    cfg_write = 1'b0;
    cyc++;
    for (int i = 0; i < FLUX; i++) exp_busy[i] = m_active[i];
    if (out_write !== e_ow) log_bad($sformatf("out_write got %b want %b", out_write, e_ow));
    if (out_din !== e_odin) log_bad($sformatf("out_din got %h want %h", out_din, e_odin));
    if (flow_done !== e_done) log_bad($sformatf("flow_done got %b want %b", flow_done, e_done));
    if (cfg_err !== e_err) log_bad($sformatf("cfg_err got %b want %b", cfg_err, e_err));
    if (flow_busy !== exp_busy) log_bad($sformatf("flow_busy got %b want %b", flow_busy, exp_busy));
    if (out_write === 1'b1) begin
      obs_words[int'(out_din[DATA_W +: TAG_W])]++;
      if (first_any < 0) first_any = cyc;
      last_any = cyc;
    end
    for (int i = 0; i < FLUX; i++) if (flow_done[i] === 1'b1) obs_done[i]++;
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int n = 0;
    while ((m_active[0] || m_active[1]) && n < budget) begin
      tick();
      n++;
    end
    timed_out = m_active[0] || m_active[1];
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_write = 1'b0; cfg_din = '0; src_valid = '1; out_full = '0; src_data = '0;
    cfg_write3 = 1'b0; cfg_din3 = '0; src_valid3 = '0; out_full3 = '0; src_data3 = '0;
    model_reset();
    #3 rst = 1'b0;
    #20;
    checks++; if (out_write !== 1'b0) begin failures++; $display("FAIL reset_out_write got %b want 0", out_write); end
    checks++; if (out_din !== '0) begin failures++; $display("FAIL reset_out_din got %h want 0", out_din); end
    checks++; if (flow_busy !== '0) begin failures++; $display("FAIL reset_flow_busy got %b want 0", flow_busy); end
    checks++; if (flow_done !== '0) begin failures++; $display("FAIL reset_flow_done got %b want 0", flow_done); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    checks++; if (src_ready !== '0) begin failures++; $display("FAIL reset_src_ready got %b want 0", src_ready); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_flow();
    int w0, d0, b0; bit to;
    w0 = obs_words[0]; d0 = obs_done[0]; b0 = cyc_bad; first_any = -1; last_any = -1;
    src_valid = 2'b01; out_full = '0;
    arm(0, 23);
    tick();
    drain(3000, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout flow0 active after 3000 cycles, want idle"); end
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL single_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
    checks++; if (obs_words[0] - w0 != 529) begin failures++; $display("FAIL single_words got %0d want 529", obs_words[0] - w0); end
    checks++; if (obs_done[0] - d0 != 1) begin failures++; $display("FAIL single_done got %0d want 1", obs_done[0] - d0); end
    checks++; if (last_any - first_any != 1056) begin failures++; $display("FAIL single_rate span got %0d want 1056", last_any - first_any); end
    checks++; if (flow_busy[0] !== 1'b0) begin failures++; $display("FAIL single_busy got %b want 0", flow_busy[0]); end
  endtask

  task automatic test_two_flows();
    int w0, w1, d0, d1, b0; bit to;
    w0 = obs_words[0]; w1 = obs_words[1]; d0 = obs_done[0]; d1 = obs_done[1];
    b0 = cyc_bad; first_any = -1; last_any = -1;
    src_valid = 2'b11; out_full = '0;
    arm(0, 23); tick();
    arm(1, 23); tick();
    drain(3000, to);
    checks++; if (to) begin failures++; $display("FAIL two_timeout flows active after 3000 cycles, want idle"); end
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL two_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
    checks++; if (obs_words[0] - w0 != 529 || obs_words[1] - w1 != 529) begin failures++; $display("FAIL two_words got %0d/%0d want 529/529", obs_words[0] - w0, obs_words[1] - w1); end
    checks++; if (obs_done[0] - d0 != 1 || obs_done[1] - d1 != 1) begin failures++; $display("FAIL two_done got %0d/%0d want 1/1", obs_done[0] - d0, obs_done[1] - d1); end
    checks++; if (last_any - first_any != 1057) begin failures++; $display("FAIL two_interleave span got %0d want 1057", last_any - first_any); end
  endtask

  task automatic test_back_pressure();
    int s0, s1, w0, w1, b0; bit to;
    s0 = obs_words[0]; s1 = obs_words[1]; b0 = cyc_bad;
    src_valid = 2'b11; out_full = '0;
    arm(0, 15); tick();
    arm(1, 15); tick();
    repeat (30) tick();
    out_full = 2'b10;
    w0 = obs_words[0]; w1 = obs_words[1];
    repeat (50) tick();
    checks++; if (obs_words[1] - w1 != 0) begin failures++; $display("FAIL bp_tag1_in_window got %0d want 0", obs_words[1] - w1); end
    checks++; if (obs_words[0] - w0 != 25) begin failures++; $display("FAIL bp_tag0_in_window got %0d want 25", obs_words[0] - w0); end
    out_full = '0;
    drain(2000, to);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout flows active after budget, want idle"); end
    checks++; if (obs_words[0] - s0 != 225 || obs_words[1] - s1 != 225) begin failures++; $display("FAIL bp_words got %0d/%0d want 225/225", obs_words[0] - s0, obs_words[1] - s1); end
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL bp_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
  endtask

  task automatic test_cfg_errors();
    int w0, b0; bit to;
    b0 = cyc_bad;
    src_valid = 2'b11; out_full = '0;
    arm(1, 0); tick();
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_zero_err got %b want 1", cfg_err); end
    checks++; if (flow_busy[1] !== 1'b0) begin failures++; $display("FAIL cfg_zero_idle busy got %b want 0", flow_busy[1]); end
    tick();
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_width got %b want 0", cfg_err); end
    // Re-arming an active flow must not disturb its count.
    w0 = obs_words[0];
    src_valid = 2'b01;
    arm(0, 4); tick();
    repeat (5) tick();
    arm(0, 9); tick();
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_active_err got %b want 1", cfg_err); end
    drain(200, to);
    checks++; if (obs_words[0] - w0 != 16) begin failures++; $display("FAIL cfg_active_words got %0d want 16", obs_words[0] - w0); end
    // Config arriving in the same cycle as the final grant.
    w0 = obs_words[0];
    arm(0, 1); tick();
    arm(0, 5); tick();
    checks++; if (cfg_err !== 1'b1 || flow_done[0] !== 1'b1) begin failures++; $display("FAIL cfg_last_collide err=%b done=%b want 1/1", cfg_err, flow_done[0]); end
    repeat (2) tick();
    checks++; if (flow_busy[0] !== 1'b0 || obs_words[0] - w0 != 1) begin failures++; $display("FAIL cfg_last_after busy=%b words=%0d want 0/1", flow_busy[0], obs_words[0] - w0); end
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL cfg_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
    // Out-of-range tag on a three-flow instance.
    cfg_din3 = {TAG3_W'(3), SIZE_W'(5)}; cfg_write3 = 1'b1;
    @(posedge clk); @(negedge clk); cfg_write3 = 1'b0;
    checks++; if (cfg_err3 !== 1'b1 || flow_busy3 !== 3'b000) begin failures++; $display("FAIL cfg_tag_range err=%b busy=%b want 1/000", cfg_err3, flow_busy3); end
    cfg_din3 = {TAG3_W'(2), SIZE_W'(1)}; cfg_write3 = 1'b1;
    @(posedge clk); @(negedge clk); cfg_write3 = 1'b0;
    checks++; if (cfg_err3 !== 1'b0 || flow_busy3 !== 3'b100) begin failures++; $display("FAIL cfg_tag_top err=%b busy=%b want 0/100", cfg_err3, flow_busy3); end
  endtask

  task automatic test_reset_mid();
    int w0, b0, n; bit to;
    src_valid = 2'b01; out_full = '0;
    w0 = obs_words[0];
    arm(0, 23); tick();
    n = 0;
    while (obs_words[0] - w0 < 100 && n < 400) begin tick(); n++; end
    checks++; if (obs_words[0] - w0 != 100) begin failures++; $display("FAIL rmid_reach got %0d words want 100", obs_words[0] - w0); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_write !== 1'b0 || out_din !== '0) begin failures++; $display("FAIL rmid_out write=%b din=%h want 0/0", out_write, out_din); end
    checks++; if (flow_busy !== '0 || flow_done !== '0 || cfg_err !== 1'b0) begin failures++; $display("FAIL rmid_status busy=%b done=%b err=%b want 0", flow_busy, flow_done, cfg_err); end
    @(negedge clk); @(negedge clk);
    model_reset();
    rst = 1'b1;
    w0 = obs_words[0]; b0 = cyc_bad;
    repeat (20) tick();
    checks++; if (obs_words[0] - w0 != 0) begin failures++; $display("FAIL rmid_idle_words got %0d want 0", obs_words[0] - w0); end
    arm(0, 2); tick();
    drain(100, to);
    checks++; if (obs_words[0] - w0 != 4) begin failures++; $display("FAIL rmid_rearm_words got %0d want 4", obs_words[0] - w0); end
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL rmid_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
  endtask

  task automatic test_random();
    int g0[FLUX], w0[FLUX], d0[FLUX], o0[FLUX];
    int b0; bit to;
    b0 = cyc_bad;
    for (int i = 0; i < FLUX; i++) begin
      g0[i] = m_grants[i]; w0[i] = obs_words[i]; d0[i] = m_dones[i]; o0[i] = obs_done[i];
    end
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < FLUX; i++) begin
        src_valid[i] = ($urandom_range(0, 3) != 0);
        out_full[i]  = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) arm($urandom_range(0, FLUX-1), $urandom_range(0, 6));
      tick();
    end
    src_valid = '1; out_full = '0;
    drain(500, to);
    checks++; if (cyc_bad - b0 != 0) begin failures++; $display("FAIL rand_cycle mismatches=%0d want 0 first: %s", cyc_bad - b0, bad_msg); end
    for (int i = 0; i < FLUX; i++) begin
      checks++;
      if (obs_words[i] - w0[i] != m_grants[i] - g0[i] || obs_done[i] - o0[i] != m_dones[i] - d0[i]) begin
        failures++;
        $display("FAIL rand_flow%0d words=%0d done=%0d want %0d/%0d", i, obs_words[i] - w0[i],
                 obs_done[i] - o0[i], m_grants[i] - g0[i], m_dones[i] - d0[i]);
      end
    end
  endtask

`ifdef MS_ARB_STATS_EN
  task automatic test_stats();
    bit to;
    src_valid = 2'b11; out_full = '0;
    arm(0, 23); tick();
    arm(1, 23); tick();
    repeat (20) tick();
    out_full = 2'b01;
    repeat (10) tick();
    out_full = '0;
    drain(3000, to);
    checks++; if (stat_grant[0 +: STAT_W] !== 16'd529 || stat_grant[STAT_W +: STAT_W] !== 16'd529) begin failures++; $display("FAIL stat_grant got %0d/%0d want 529/529", stat_grant[0 +: STAT_W], stat_grant[STAT_W +: STAT_W]); end
    checks++; if (int'(stat_stall[0 +: STAT_W]) != m_stall[0] || m_stall[0] < 10) begin failures++; $display("FAIL stat_stall0 got %0d want %0d (>=10)", stat_stall[0 +: STAT_W], m_stall[0]); end
    checks++; if (int'(stat_stall[STAT_W +: STAT_W]) != m_stall[1]) begin failures++; $display("FAIL stat_stall1 got %0d want %0d", stat_stall[STAT_W +: STAT_W], m_stall[1]); end
  endtask
`endif

  initial begin
    for (int i = 0; i < FLUX; i++) begin
      seq[i] = 0; m_grants[i] = 0; m_dones[i] = 0; m_sg[i] = 0; m_stall[i] = 0;
      obs_words[i] = 0; obs_done[i] = 0;
    end
    test_reset();
    test_single_flow();
    test_two_flows();
    test_back_pressure();
    test_cfg_errors();
    test_reset_mid();
    test_random();
`ifdef MS_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
